// File: rtl/zxuno_spi_pkg.sv
// Shared definitions for the SPI bus arbiter and its byte engine.
//   arb_state_t : arbiter FSM states
//   DEV_FLASH / DEV_SD : device select values carried on dev0/dev1
//   BIT_CNT_W   : width of the per-byte bit counter
package zxuno_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam logic DEV_FLASH = 1'b0;
    localparam logic DEV_SD    = 1'b1;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: SCK divider, bit counter, TX/RX shift registers.
// Ports:
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_load, i_tx   : start a byte with the given TX value
//   i_miso         : serial input, sampled on each SCK rising edge
//   o_sck, o_mosi  : serial clock and data out (MOSI idles high)
//   o_rx           : last complete received byte
//   o_done         : one-cycle pulse after the 8th SCK falling edge
//   o_last         : high in the cycle whose closing edge ends the byte
module spi_byte_engine
    import zxuno_spi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_tx,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic [7:0] o_rx,
    output logic       o_done,
    output logic       o_last
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = {BIT_CNT_W{1'b1}};

    logic                 r_active;
    logic                 r_sck;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]           r_tx_sh;
    logic [7:0]           r_rx_sh;
    logic [7:0]           r_rx;
    logic                 r_done;

    logic w_half_tc;

    assign w_half_tc = r_active && (r_div_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active  <= 1'b0;
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_active  <= 1'b1;
                r_sck     <= 1'b0;
                r_div_cnt <= DIV_LOAD;
                r_bit_cnt <= '0;
                r_tx_sh   <= i_tx;
            end else if (r_active) begin
                if (!w_half_tc) begin
                    r_div_cnt <= r_div_cnt - DIV_W'(1);
                end else begin
                    r_div_cnt <= DIV_LOAD;
                    if (!r_sck) begin
                        // Rising edge: the pin goes high just after this
                        // clock edge, so MISO is captured as SCK rises.
                        r_sck   <= 1'b1;
                        r_rx_sh <= {r_rx_sh[6:0], i_miso};
                    end else begin
                        r_sck <= 1'b0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                            r_rx     <= r_rx_sh;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                            r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign o_sck  = r_sck;
    assign o_mosi = r_active ? r_tx_sh[7] : 1'b1;
    assign o_rx   = r_rx;
    assign o_done = r_done;
    assign o_last = w_half_tc && r_sck && (r_bit_cnt == LAST_BIT);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter for the shared flash/SD SPI bus. Requester 0 (boot
// loader) has priority, requester 1 is the CPU SPI port. Handles chip-select
// sequencing, the inter-ownership gap and the stretched activity LED; byte
// shifting is delegated to spi_byte_engine.
// Ports:
//   sysclk, power_on_reset_n : clock, synchronous active-low reset
//   req0/1, dev0/1           : bus request and target device (0 flash, 1 SD)
//   start0/1, tx0/1          : byte start strobe and TX byte
//   gnt0/1, busy, done       : ownership, shift in progress, byte complete
//   rx_data                  : received byte
//   flash_cs_n, sd_cs_n      : chip selects
//   spi_clk, spi_mosi, spi_miso : SPI lines
//   activity_led             : stretched bus activity indicator
//
// state | meaning
// IDLE  | no owner, arbitrate pending requests
// OWN   | owner holds CS low, waiting for a start strobe or release
// SHIFT | byte in flight
// GAP   | both CS high before the next arbitration
module spi_bus_arbiter
    import zxuno_spi_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int CS_GAP   = 2,
    parameter int LED_HOLD = 1400000
) (
    input  logic       sysclk,
    input  logic       power_on_reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       dev0,
    input  logic       dev1,
    input  logic       start0,
    input  logic       start1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       flash_cs_n,
    output logic       sd_cs_n,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       activity_led
);

    // The IDLE arbitration cycle also has both CS high, so GAP itself only
    // needs CS_GAP-1 cycles (at least one) to honour the minimum gap.
    localparam int GAP_W    = $clog2(CS_GAP + 2);
    localparam int GAP_CYC  = (CS_GAP > 1) ? CS_GAP - 1 : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
    localparam logic [20:0] LED_LOAD = 21'(LED_HOLD);

    arb_state_t       r_state;
    logic             r_owner;
    logic             r_dev;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [20:0]      r_led_cnt;

    arb_state_t       w_state_nxt;
    logic             w_owner_nxt;
    logic             w_dev_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_load;
    logic             w_own_req;
    logic             w_own_start;
    logic [7:0]       w_own_tx;
    logic             w_owning;
    logic             w_eng_done;
    logic             w_eng_last;

    assign w_own_req   = r_owner ? req1 : req0;
    assign w_own_start = r_owner ? start1 : start0;
    assign w_own_tx    = r_owner ? tx1 : tx0;

    always_ff @(posedge sysclk) begin
        if (!power_on_reset_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_dev     <= DEV_FLASH;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_dev     <= w_dev_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_dev_nxt   = r_dev;
        w_gap_nxt   = r_gap_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = 1'b0;
                    w_dev_nxt   = dev0;
                end else if (req1) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = 1'b1;
                    w_dev_nxt   = dev1;
                end
            end
            OWN: begin
                if (!w_own_req) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = GAP_LOAD;
                end else if (w_own_start) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_eng_last) begin
                    w_state_nxt = OWN;
                end
            end
            GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_owning = (r_state == OWN) || (r_state == SHIFT);

    // Reloads while any CS is low, so the hold time runs from the last
    // deassertion; saturates at zero.
    always_ff @(posedge sysclk) begin
        if (!power_on_reset_n) begin
            r_led_cnt <= '0;
        end else if (w_owning) begin
            r_led_cnt <= LED_LOAD;
        end else if (r_led_cnt != '0) begin
            r_led_cnt <= r_led_cnt - 21'd1;
        end
    end

    spi_byte_engine #(
        .DIV (DIV)
    ) u_engine (
        .i_clk   (sysclk),
        .i_rst_n (power_on_reset_n),
        .i_load  (w_load),
        .i_tx    (w_own_tx),
        .i_miso  (spi_miso),
        .o_sck   (spi_clk),
        .o_mosi  (spi_mosi),
        .o_rx    (rx_data),
        .o_done  (w_eng_done),
        .o_last  (w_eng_last)
    );

    assign gnt0         = w_owning && !r_owner;
    assign gnt1         = w_owning && r_owner;
    assign busy         = (r_state == SHIFT);
    assign done         = w_eng_done && w_owning;
    assign flash_cs_n   = !(w_owning && (r_dev == DEV_FLASH));
    assign sd_cs_n      = !(w_owning && (r_dev == DEV_SD));
    assign activity_led = w_owning || (r_led_cnt != '0);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (DIV=2, CS_GAP=2, LED_HOLD=8) with a
// behavioural SPI slave that returns a preset byte and captures MOSI.
module tb_spi_bus_arbiter;

    logic       sysclk = 1'b0;
    logic       power_on_reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       dev0 = 1'b0, dev1 = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
    logic       gnt0, gnt1, busy, done;
    logic [7:0] rx_data;
    logic       flash_cs_n, sd_cs_n, spi_clk, spi_mosi, spi_miso, activity_led;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] slv_byte = 8'hFF;
    logic [7:0] mosi_cap = 8'h00;
    int fall_cnt = 0;
    int fall_base = 0;
    int rise_cnt = 0;
    int rise_base = 0;
    int done_cnt = 0;
    int w_k;
    logic [2:0] w_idx;

    spi_bus_arbiter #(
        .DIV      (2),
        .CS_GAP   (2),
        .LED_HOLD (8)
    ) dut (
        .sysclk           (sysclk),
        .power_on_reset_n (power_on_reset_n),
        .req0             (req0),
        .req1             (req1),
        .dev0             (dev0),
        .dev1             (dev1),
        .start0           (start0),
        .start1           (start1),
        .tx0              (tx0),
        .tx1              (tx1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .busy             (busy),
        .done             (done),
        .rx_data          (rx_data),
        .flash_cs_n       (flash_cs_n),
        .sd_cs_n          (sd_cs_n),
        .spi_clk          (spi_clk),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .activity_led     (activity_led)
    );

    always #5 sysclk = ~sysclk;

    // Slave: shifts a new MISO bit after each SCK fall, captures MOSI on rise.
    always @(negedge spi_clk) fall_cnt = fall_cnt + 1;
    always @(posedge spi_clk) begin
        mosi_cap = {mosi_cap[6:0], spi_mosi};
        rise_cnt = rise_cnt + 1;
    end
    always @(posedge sysclk) if (done) done_cnt = done_cnt + 1;

    assign w_k = fall_cnt - fall_base;
    assign w_idx = 3'(7 - w_k);
    assign spi_miso = (w_k >= 0 && w_k < 8) ? slv_byte[w_idx] : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic begin_byte(input logic [7:0] miso_byte);
        slv_byte  = miso_byte;
        fall_base = fall_cnt;
        rise_base = rise_cnt;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_gnt1();
        int n = 0;
        while (!gnt1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int s;
        int d0;
        int r0;

        // 1: reset and quiet bus
        tick();
        tick();
        check("rst_outputs", {flash_cs_n, sd_cs_n, spi_clk, spi_mosi, gnt1, gnt0, busy, done, activity_led}, 9'b110100000);
        check("rst_rx", rx_data, 8'h00);
        power_on_reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", {flash_cs_n, sd_cs_n, spi_clk, spi_mosi, gnt1, gnt0, busy, done, activity_led}, 9'b110100000);
        end

        // 2: requester 1, flash, tx A5 / rx 3C
        dev1 = 1'b0;
        req1 = 1'b1;
        tick();
        check("t2_gnt", {gnt1, gnt0}, 2'b10);
        check("t2_cs", {flash_cs_n, sd_cs_n}, 2'b01);
        check("t2_led_on", activity_led, 1'b1);
        begin_byte(8'h3C);
        start1 = 1'b1;
        tx1 = 8'hA5;
        tick();
        s = cyc;
        start1 = 1'b0;
        tx1 = 8'h00;
        check("t2_busy", busy, 1'b1);
        check("t2_mosi_msb", spi_mosi, 1'b1);
        wait_done();
        check("t2_done", done, 1'b1);
        check("t2_latency", cyc - s + 1, 33);
        check("t2_rx", rx_data, 8'h3C);
        check("t2_mosi_bits", mosi_cap, 8'hA5);
        check("t2_sck_pulses", rise_cnt - rise_base, 8);
        check("t2_busy_end", busy, 1'b0);
        tick();
        check("t2_done_1cyc", done, 1'b0);
        check("t2_mosi_idle", spi_mosi, 1'b1);
        req1 = 1'b0;
        tick();
        check("t2_release", {flash_cs_n, sd_cs_n, gnt1, gnt0}, 4'b1100);
        repeat (4) tick();

        // 3: simultaneous requests, requester 0 to SD wins
        dev0 = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        check("t3_gnt", {gnt1, gnt0}, 2'b01);
        check("t3_cs", {flash_cs_n, sd_cs_n}, 2'b10);
        tick();
        tick();
        check("t3_gnt1_waits", gnt1, 1'b0);
        req0 = 1'b0;
        tick();
        check("t3_gap1", {flash_cs_n, sd_cs_n, gnt1, gnt0}, 4'b1100);
        tick();
        check("t3_gap2", {flash_cs_n, sd_cs_n, gnt1, gnt0}, 4'b1100);
        tick();
        check("t3_gnt1", {gnt1, gnt0}, 2'b10);
        check("t3_cs1", {flash_cs_n, sd_cs_n}, 2'b01);

        // 4: requester 1 drops mid-byte while requester 0 asks
        begin_byte(8'hC3);
        start1 = 1'b1;
        tx1 = 8'h5A;
        tick();
        s = cyc;
        start1 = 1'b0;
        repeat (13) tick();
        req0 = 1'b1;
        req1 = 1'b0;
        wait_done();
        check("t4_done", done, 1'b1);
        check("t4_latency", cyc - s + 1, 33);
        check("t4_rx", rx_data, 8'hC3);
        check("t4_mosi_bits", mosi_cap, 8'h5A);
        check("t4_gnt_at_done", {gnt1, gnt0}, 2'b10);
        tick();
        check("t4_gap1", {flash_cs_n, sd_cs_n, gnt1, gnt0}, 4'b1100);
        tick();
        check("t4_gap2", {flash_cs_n, sd_cs_n, gnt1, gnt0}, 4'b1100);
        tick();
        check("t4_gnt0", {gnt1, gnt0}, 2'b01);
        check("t4_cs0", {flash_cs_n, sd_cs_n}, 2'b10);

        // 5: ignored strobes and dev change while owning
        req0 = 1'b0;
        req1 = 1'b1;
        dev1 = 1'b0;
        wait_gnt1();
        check("t5_gnt1", {gnt1, gnt0}, 2'b10);
        dev1 = 1'b1;
        d0 = done_cnt;
        r0 = rise_cnt;
        start0 = 1'b1;
        tx0 = 8'hFF;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        check("t5_nonowner_busy", busy, 1'b0);
        check("t5_nonowner_sck", rise_cnt - r0, 0);
        check("t5_dev_latched", {flash_cs_n, sd_cs_n}, 2'b01);
        begin_byte(8'h7E);
        start1 = 1'b1;
        tx1 = 8'h81;
        tick();
        s = cyc;
        start1 = 1'b0;
        repeat (4) tick();
        start1 = 1'b1;
        start0 = 1'b1;
        tx1 = 8'h00;
        tick();
        start1 = 1'b0;
        start0 = 1'b0;
        wait_done();
        check("t5_latency", cyc - s + 1, 33);
        check("t5_rx", rx_data, 8'h7E);
        check("t5_mosi_bits", mosi_cap, 8'h81);
        repeat (40) tick();
        check("t5_sck_pulses", rise_cnt - r0, 8);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_idle_own", {busy, gnt1}, 2'b01);

        // 6: reset at bit 5, then LED stretch after a clean release
        begin_byte(8'h96);
        d0 = done_cnt;
        start1 = 1'b1;
        tx1 = 8'hF0;
        tick();
        start1 = 1'b0;
        repeat (21) tick();
        power_on_reset_n = 1'b0;
        tick();
        check("t6_rst_outputs", {flash_cs_n, sd_cs_n, spi_clk, spi_mosi, gnt1, gnt0, busy, done, activity_led}, 9'b110100000);
        check("t6_rst_rx", rx_data, 8'h7E ^ 8'h7E);
        tick();
        check("t6_no_done", done_cnt - d0, 0);
        power_on_reset_n = 1'b1;
        dev1 = 1'b0;
        tick();
        check("t6_regrant", {gnt1, flash_cs_n}, 2'b10);
        tick();
        req1 = 1'b0;
        tick();
        check("t6_cs_high", {flash_cs_n, sd_cs_n}, 2'b11);
        for (int i = 0; i < 8; i++) begin
            check("t6_led_hold", activity_led, 1'b1);
            tick();
        end
        check("t6_led_off", activity_led, 1'b0);
        tick();
        check("t6_led_stays_off", activity_led, 1'b0);
        check("t6_no_done_total", done_cnt - d0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the board's single SPI bus (flash_*, sd_*) between two requesters.
  - Requester 0: boot/ROM loader, high priority.
  - Requester 1: CPU SPI I/O port.
- Owns chip-select sequencing, byte-wide SPI mode-0 shifting and the SPI activity LED.
- Sits between the zxuno core's SPI users and the top-level flash/SD pins.

Parameters:
- DIV, 2, SCK half-period in sysclk cycles (≥1); one byte takes 16*DIV cycles.
- CS_GAP, 2, minimum cycles both CS lines stay high between ownerships (≥1).
- LED_HOLD, 1400000, cycles the activity LED stays lit after the last CS deassertion (0 = no stretch).

Ports:
- sysclk  in  1  system clock
- power_on_reset_n  in  1  synchronous active-low reset
- req0, req1  in  1 each  bus request; held for the whole frame
- dev0, dev1  in  1 each  target device, 0 = flash, 1 = SD; sampled at grant
- start0, start1  in  1 each  one-cycle strobe that begins a byte transfer
- tx0, tx1  in  8 each  byte to send; sampled on the start strobe
- gnt0, gnt1  out  1 each  requester owns the bus
- busy  out  1  byte shift in progress
- done  out  1  one-cycle pulse at the end of a byte, qualified by gnt
- rx_data  out  8  received byte; valid from done until the next start
- flash_cs_n, sd_cs_n  out  1 each  chip selects, active low
- spi_clk  out  1  SCK, shared by both devices
- spi_mosi  out  1  MOSI
- spi_miso  in  1  MISO (flash_miso/sd_miso multiplexed upstream by CS)
- activity_led  out  1  stretched SPI-activity indicator

Behaviour:
- Clock and reset: one clock, sysclk. Reset is synchronous and active low on power_on_reset_n.
- Reset values: both CS = 1, spi_clk = 0, spi_mosi = 1, gnt* = 0, busy = 0, done = 0, rx_data = 0x00, activity_led = 0, FSM = IDLE.
- FSM states: IDLE, OWN, SHIFT, GAP.
- IDLE:
  - A request seen at edge N gives gnt and CS low at edge N+1.
  - req0 wins when both requests are present.
  - The device is latched from dev*, which selects the CS line.
  - Go to OWN.
- OWN:
  - A start strobe from the owner loads tx into the shifter; busy = 1; go to SHIFT.
  - If the owner drops req, both CS go high on the next edge and the FSM goes to GAP.
- SHIFT (mode 0):
  - MOSI carries the MSB before the first rising edge.
  - MISO is sampled on each rising SCK edge.
  - MOSI advances on each falling edge.
  - Exactly 8 SCK pulses, each high/low for DIV cycles.
  - After the 8th falling edge: rx_data updates, done pulses for 1 cycle, busy = 0, go to OWN.
  - Latency from the start strobe to done = 16*DIV + 1 cycles.
- Dropping req during SHIFT: the byte completes and done still pulses. Release then follows from OWN on the next cycle.
- GAP: CS_GAP cycles with both CS high, then IDLE. Requests are not granted during GAP.
- Ignored inputs:
  - start from a non-owner.
  - start while busy.
  - start in the same cycle as the grant, since start is only valid once gnt = 1.
  - A change of dev* while owning. The latched device holds for the whole frame.
- No preemption: req0 waits for requester 1's frame to end. Requests are re-arbitrated at every IDLE, so requester 1 starves if req0 is held continuously. This is accepted: the boot loader runs only at start-up.
- Reset mid-transfer: the next edge forces the reset values. A partial byte is discarded and no done pulse is produced.
- spi_mosi idles at 1 outside SHIFT.
- activity_led:
  - 1 whenever either CS is low.
  - After CS goes high, stays 1 for LED_HOLD cycles, counted down by a 21-bit counter.
  - The counter reloads on any new CS assertion; no wrap.

Decomposition:
- Shared package zxuno_spi_pkg:
  - FSM state enum (IDLE/OWN/SHIFT/GAP).
  - Device constants DEV_FLASH = 0, DEV_SD = 1.
  - Bit-counter width constant (3).
- Sub-module spi_byte_engine handles byte shifting only:
  - Inputs: load, tx.
  - Outputs: sck, mosi, rx, done.
  - Contains the DIV divider, bit counter and shifter.
- The arbiter, CS control, GAP counter and LED stretcher stay in the top of the block.

Test Plan (DIV=2, CS_GAP=2, LED_HOLD=8):
1. Reset, no requests -> both CS = 1, spi_clk = 0, spi_mosi = 1, gnt = 00, led = 0 for 20 cycles.
2. req1 = 1, dev1 = 0; after gnt1, start1 with tx1 = 0xA5 and MISO driven 0x3C -> flash_cs_n low.
   - MOSI bits 1,0,1,0,0,1,0,1 at the rising edges.
   - done 33 cycles after the start strobe; rx_data = 0x3C.
3. req0 and req1 rise in the same cycle, dev0 = 1 -> gnt0 next edge, sd_cs_n low, gnt1 stays 0.
   - After req0 drops: CS high for 2 cycles, then gnt1.
4. req1 owns and is mid-byte; req0 rises and req1 drops at bit 3 -> byte completes with done.
   - CS high 1 cycle after done, 2-cycle gap, then gnt0.
5. start0 pulsed while requester 1 owns; start1 pulsed while busy -> no extra SCK pulses, one done only.
6. Reset asserted at bit 5 -> next edge gives CS high, spi_clk = 0, no done.
   - After CS deassertion with reset released, led stays 1 for exactly 8 cycles.
